// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master bridge and its wait timer.
package apb_pkg;

    localparam int PPROT_W    = 3;
    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    typedef struct packed {
        logic [APB_ADDR_W-1:0]   addr;
        logic                    write;
        logic [APB_DATA_W-1:0]   wdata;
        logic [APB_DATA_W/8-1:0] strb;
        logic [PPROT_W-1:0]      prot;
    } apb_cmd_t;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  slverr;
        logic                  timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating counter of stalled ACCESS cycles; flags the cycle in which the
// stall limit is reached. A limit of 0 disables expiry.
module apb_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_count_en,
    output logic o_expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [CNT_W-1:0] r_count;

    // Count stalled cycles, saturating at the limit.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= {CNT_W{1'b0}};
        end else if (i_count_en && (r_count != LIMIT)) begin
            r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // This stalled cycle is the one that brings the count to the limit.
    assign o_expired = (TIMEOUT_CYCLES != 0) && i_count_en && (r_count >= LIMIT_M1);

endmodule

// File: rtl/apb_master_bridge.sv
// Converts a valid/ready command stream into single APB4 transfers and
// returns each result, or a timeout abort, on a valid/ready response stream.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic                  cmd_write,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_strb,
    input  logic [PPROT_W-1:0]    cmd_prot,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_slverr,
    output logic                  rsp_timeout,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_W-1:0]     PADDR,
    output logic [DATA_W-1:0]     PWDATA,
    output logic [DATA_W/8-1:0]   PSTRB,
    output logic [PPROT_W-1:0]    PPROT,
    input  logic [DATA_W-1:0]     PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam int STRB_W = DATA_W / 8;

    apb_state_e          r_state;
    logic                r_psel;
    logic                r_penable;
    logic                r_pwrite;
    logic [ADDR_W-1:0]   r_paddr;
    logic [DATA_W-1:0]   r_pwdata;
    logic [STRB_W-1:0]   r_pstrb;
    logic [PPROT_W-1:0]  r_pprot;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_slverr;
    logic                r_rsp_timeout;

    logic w_accept;
    logic w_count_en;
    logic w_expired;

    assign cmd_ready  = (r_state == IDLE) && !PRESET;
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_count_en = (r_state == ACCESS) && !PREADY;

    apb_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .i_clk      (PCLK),
        .i_rst      (PRESET),
        .i_clear    (w_accept),
        .i_count_en (w_count_en),
        .o_expired  (w_expired)
    );

    // Transfer sequencer: IDLE -> SETUP -> ACCESS (waits) -> RESP -> IDLE.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state       <= IDLE;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= {ADDR_W{1'b0}};
            r_pwdata      <= {DATA_W{1'b0}};
            r_pstrb       <= {STRB_W{1'b0}};
            r_pprot       <= {PPROT_W{1'b0}};
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= {DATA_W{1'b0}};
            r_rsp_slverr  <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state   <= SETUP;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_pwrite  <= cmd_write;
                        r_paddr   <= cmd_addr;
                        r_pprot   <= cmd_prot;
                        // Reads never expose stale write data or strobes.
                        r_pwdata  <= cmd_write ? cmd_wdata : {DATA_W{1'b0}};
                        r_pstrb   <= cmd_write ? cmd_strb  : {STRB_W{1'b0}};
                    end
                end
                SETUP: begin
                    r_state   <= ACCESS;
                    r_penable <= 1'b1;
                end
                ACCESS: begin
                    if (PREADY) begin
                        r_state       <= RESP;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= r_pwrite ? {DATA_W{1'b0}} : PRDATA;
                        r_rsp_slverr  <= PSLVERR;
                        r_rsp_timeout <= 1'b0;
                    end else if (w_expired) begin
                        r_state       <= RESP;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= {DATA_W{1'b0}};
                        r_rsp_slverr  <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                end
            endcase
        end
    end

    assign PSEL        = r_psel;
    assign PENABLE     = r_penable;
    assign PWRITE      = r_pwrite;
    assign PADDR       = r_paddr;
    assign PWDATA      = r_pwdata;
    assign PSTRB       = r_pstrb;
    assign PPROT       = r_pprot;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_slverr  = r_rsp_slverr;
    assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: inputs driven and outputs checked on
// the falling edge, each step against hand-computed values.
module tb_apb_master_bridge;

    logic        PCLK;
    logic        PRESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic        cmd_write;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic [2:0]  cmd_prot;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_slverr;
    logic        rsp_timeout;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int vectors;
    int miscompares;

    apb_master_bridge #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_write   (cmd_write),
        .cmd_wdata   (cmd_wdata),
        .cmd_strb    (cmd_strb),
        .cmd_prot    (cmd_prot),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_slverr  (rsp_slverr),
        .rsp_timeout (rsp_timeout),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PSTRB       (PSTRB),
        .PPROT       (PPROT),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
            $error("miscompare on %s", tag);
        end
    endtask

    task automatic step();
        @(negedge PCLK);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = 32'h0;
        cmd_write = 1'b0;
        cmd_wdata = 32'h0;
        cmd_strb  = 4'h0;
        cmd_prot  = 3'h0;
        rsp_ready = 1'b0;
        PRDATA    = 32'h0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_psel",      {31'd0, PSEL},      32'd0);
        chk("rst_penable",   {31'd0, PENABLE},   32'd0);
        chk("rst_pwrite",    {31'd0, PWRITE},    32'd0);
        chk("rst_paddr",     PADDR,              32'd0);
        chk("rst_pwdata",    PWDATA,             32'd0);
        chk("rst_pstrb",     {28'd0, PSTRB},     32'd0);
        chk("rst_pprot",     {29'd0, PPROT},     32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rdata",     rsp_rdata,          32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        PRESET = 1'b0;
        #1;
        chk("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Write, zero wait states
        cmd_valid = 1'b1; cmd_addr = 32'h10; cmd_write = 1'b1;
        cmd_wdata = 32'hDEADBEEF; cmd_strb = 4'hF; cmd_prot = 3'b010;
        PREADY = 1'b1; rsp_ready = 1'b1;
        step();
        cmd_valid = 1'b0; cmd_wdata = 32'h0; cmd_addr = 32'hFFFF_FFFF;
        chk("wr_setup_psel",    {31'd0, PSEL},      32'd1);
        chk("wr_setup_penable", {31'd0, PENABLE},   32'd0);
        chk("wr_setup_paddr",   PADDR,              32'h10);
        chk("wr_setup_pwdata",  PWDATA,             32'hDEADBEEF);
        chk("wr_setup_pstrb",   {28'd0, PSTRB},     32'hF);
        chk("wr_setup_pwrite",  {31'd0, PWRITE},    32'd1);
        chk("wr_setup_pprot",   {29'd0, PPROT},     32'd2);
        chk("wr_setup_cmdrdy",  {31'd0, cmd_ready}, 32'd0);
        step();
        chk("wr_access_psel",    {31'd0, PSEL},    32'd1);
        chk("wr_access_penable", {31'd0, PENABLE}, 32'd1);
        chk("wr_access_pwdata",  PWDATA,           32'hDEADBEEF);
        chk("wr_access_paddr",   PADDR,            32'h10);
        step();
        chk("wr_resp_psel",    {31'd0, PSEL},        32'd0);
        chk("wr_resp_penable", {31'd0, PENABLE},     32'd0);
        chk("wr_resp_valid",   {31'd0, rsp_valid},   32'd1);
        chk("wr_resp_slverr",  {31'd0, rsp_slverr},  32'd0);
        chk("wr_resp_timeout", {31'd0, rsp_timeout}, 32'd0);
        chk("wr_resp_rdata",   rsp_rdata,            32'd0);
        step();
        chk("wr_idle_valid",  {31'd0, rsp_valid}, 32'd0);
        chk("wr_idle_cmdrdy", {31'd0, cmd_ready}, 32'd1);

        // Read with three wait states
        cmd_valid = 1'b1; cmd_addr = 32'h20; cmd_write = 1'b0;
        cmd_wdata = 32'hFFFF_FFFF; cmd_strb = 4'hF; cmd_prot = 3'b101;
        PREADY = 1'b0; PRDATA = 32'h12345678; rsp_ready = 1'b0;
        step();
        cmd_valid = 1'b0;
        chk("rd_setup_paddr",  PADDR,           32'h20);
        chk("rd_setup_pstrb",  {28'd0, PSTRB},  32'h0);
        chk("rd_setup_pwdata", PWDATA,          32'h0);
        chk("rd_setup_pwrite", {31'd0, PWRITE}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("rd_access%0d_penable", i), {31'd0, PENABLE}, 32'd1);
            chk($sformatf("rd_access%0d_psel", i),    {31'd0, PSEL},    32'd1);
            chk($sformatf("rd_access%0d_paddr", i),   PADDR,            32'h20);
            chk($sformatf("rd_access%0d_pprot", i),   {29'd0, PPROT},   32'd5);
            chk($sformatf("rd_access%0d_rspv", i),    {31'd0, rsp_valid}, 32'd0);
            if (i == 3) PREADY = 1'b1;
        end
        step();
        PREADY = 1'b0; PRDATA = 32'h0;
        chk("rd_resp_valid",   {31'd0, rsp_valid},   32'd1);
        chk("rd_resp_rdata",   rsp_rdata,            32'h12345678);
        chk("rd_resp_slverr",  {31'd0, rsp_slverr},  32'd0);
        chk("rd_resp_timeout", {31'd0, rsp_timeout}, 32'd0);

        // Response back-pressure with a pending command
        cmd_valid = 1'b1; cmd_addr = 32'h30; cmd_write = 1'b0; cmd_prot = 3'b000;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d_valid", i),  {31'd0, rsp_valid}, 32'd1);
            chk($sformatf("bp%0d_rdata", i),  rsp_rdata,          32'h12345678);
            chk($sformatf("bp%0d_cmdrdy", i), {31'd0, cmd_ready}, 32'd0);
            chk($sformatf("bp%0d_psel", i),   {31'd0, PSEL},      32'd0);
            chk($sformatf("bp%0d_paddr", i),  PADDR,              32'h20);
            step();
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_idle_valid",  {31'd0, rsp_valid}, 32'd0);
        chk("bp_idle_cmdrdy", {31'd0, cmd_ready}, 32'd1);
        chk("bp_idle_psel",   {31'd0, PSEL},      32'd0);
        step();

        // Read completing with PSLVERR
        cmd_valid = 1'b0;
        chk("err_setup_psel",    {31'd0, PSEL},    32'd1);
        chk("err_setup_penable", {31'd0, PENABLE}, 32'd0);
        chk("err_setup_paddr",   PADDR,            32'h30);
        PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'hA5A50001;
        step();
        chk("err_access_penable", {31'd0, PENABLE}, 32'd1);
        step();
        PREADY = 1'b0; PSLVERR = 1'b0;
        chk("err_resp_valid",   {31'd0, rsp_valid},   32'd1);
        chk("err_resp_slverr",  {31'd0, rsp_slverr},  32'd1);
        chk("err_resp_timeout", {31'd0, rsp_timeout}, 32'd0);
        chk("err_resp_rdata",   rsp_rdata,            32'hA5A50001);
        step();
        chk("err_idle_valid",  {31'd0, rsp_valid}, 32'd0);
        chk("err_idle_cmdrdy", {31'd0, cmd_ready}, 32'd1);

        // Slave never ready: abort after exactly 16 ACCESS cycles
        cmd_valid = 1'b1; cmd_addr = 32'h40; cmd_write = 1'b0; cmd_prot = 3'b001;
        PRDATA = 32'hCAFEF00D;
        step();
        cmd_valid = 1'b0;
        chk("to_setup_psel", {31'd0, PSEL}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            step();
            chk($sformatf("to_access%0d_penable", i), {31'd0, PENABLE}, 32'd1);
        end
        step();
        chk("to_resp_psel",    {31'd0, PSEL},        32'd0);
        chk("to_resp_penable", {31'd0, PENABLE},     32'd0);
        chk("to_resp_valid",   {31'd0, rsp_valid},   32'd1);
        chk("to_resp_timeout", {31'd0, rsp_timeout}, 32'd1);
        chk("to_resp_slverr",  {31'd0, rsp_slverr},  32'd1);
        chk("to_resp_rdata",   rsp_rdata,            32'd0);
        step();
        chk("to_idle_valid", {31'd0, rsp_valid}, 32'd0);

        // Reset pulsed during ACCESS
        cmd_valid = 1'b1; cmd_addr = 32'h50; cmd_write = 1'b1;
        cmd_wdata = 32'h0BADF00D; cmd_strb = 4'h3; cmd_prot = 3'b111;
        step();
        step();
        chk("rs_access_penable", {31'd0, PENABLE}, 32'd1);
        PRESET = 1'b1;
        step();
        chk("rs_psel",      {31'd0, PSEL},      32'd0);
        chk("rs_penable",   {31'd0, PENABLE},   32'd0);
        chk("rs_pwrite",    {31'd0, PWRITE},    32'd0);
        chk("rs_paddr",     PADDR,              32'd0);
        chk("rs_pwdata",    PWDATA,             32'd0);
        chk("rs_pstrb",     {28'd0, PSTRB},     32'd0);
        chk("rs_pprot",     {29'd0, PPROT},     32'd0);
        chk("rs_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rs_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        step();
        chk("rs_hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rs_hold_psel",      {31'd0, PSEL},      32'd0);
        PRESET = 1'b0;
        #1;
        chk("rs_release_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        step();
        cmd_valid = 1'b0;
        chk("rs_new_setup_psel",  {31'd0, PSEL}, 32'd1);
        chk("rs_new_setup_paddr", PADDR,         32'h50);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Converts a simple valid/ready command stream into single APB4 transfers and returns each result on a valid/ready response stream.
- Sits directly upstream of the APB bus: it generates PSEL/PENABLE/PADDR/PWRITE/PWDATA/PSTRB/PPROT, and the APB protocol checker monitors what it drives.
- Enforces one outstanding transfer, always inserts an IDLE cycle between transfers, and aborts any transfer whose slave stalls too long.

Parameters:
- ADDR_W, 32, APB address width.
- DATA_W, 32, APB data width; must be a multiple of 8.
- TIMEOUT_CYCLES, 16, ACCESS cycles with PREADY low before the transfer is aborted; 0 disables the timeout.

Ports:
- PCLK  in  1  single clock; all logic on its rising edge.
- PRESET  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  bridge accepts a command this cycle.
- cmd_addr  in  ADDR_W  target address.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_wdata  in  DATA_W  write data.
- cmd_strb  in  DATA_W/8  byte strobes for writes.
- cmd_prot  in  3  protection attributes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  DATA_W  read data; 0 for writes and on timeout.
- rsp_slverr  out  1  PSLVERR captured, or forced to 1 on timeout.
- rsp_timeout  out  1  transfer was aborted by the timer.
- PSEL, PENABLE, PWRITE  out  1  APB control.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PSTRB  out  DATA_W/8  APB write strobes.
- PPROT  out  3  APB protection.
- PRDATA  in  DATA_W  APB read data.
- PREADY, PSLVERR  in  1  APB completion and error.

Behaviour:
- Interface: one clock, PCLK; synchronous active-high reset, PRESET. Polarity and synchronicity are fixed.
- Reset values:
  - State is IDLE.
  - All APB outputs are 0.
  - rsp_valid, rsp_slverr and rsp_timeout are 0; rsp_rdata is 0.
  - cmd_ready is 0 while PRESET is high.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready = 1 (combinational from the state register).
  - On cmd_valid && cmd_ready, register the command onto PADDR/PWRITE/PWDATA/PSTRB/PPROT and go to SETUP.
  - For reads, PSTRB and PWDATA are driven 0.
- SETUP: PSEL = 1, PENABLE = 0; lasts exactly one cycle, then ACCESS.
- ACCESS:
  - PSEL = 1, PENABLE = 1.
  - PADDR, PWRITE, PWDATA, PSTRB and PPROT hold stable until the transfer completes or aborts.
  - If PREADY = 1: capture rsp_rdata (PRDATA for reads, 0 for writes), rsp_slverr = PSLVERR and rsp_timeout = 0, then go to RESP. PSEL and PENABLE are 0 in the next cycle.
- Wait timer:
  - Counts ACCESS cycles with PREADY = 0; width is clog2(TIMEOUT_CYCLES+1) and it saturates.
  - Cleared on entry to SETUP.
  - When the count reaches TIMEOUT_CYCLES with PREADY still low, abort: go to RESP with rsp_timeout = 1, rsp_slverr = 1, rsp_rdata = 0, and PSEL/PENABLE low next cycle.
  - If PREADY is high in the same cycle the limit is reached, normal completion wins.
- RESP:
  - rsp_valid = 1; response fields stay stable until rsp_ready.
  - On rsp_valid && rsp_ready, go to IDLE.
  - No new command is accepted in RESP, so an IDLE cycle always separates transfers.
- Latency:
  - Command accepted at edge N.
  - SETUP in cycle N+1, ACCESS from cycle N+2.
  - With zero wait states and rsp_ready high, rsp_valid is high in N+3 and the next command is accepted in N+4.
  - Peak throughput is one transfer per 4 cycles.
- PREADY and PSLVERR are ignored outside ACCESS.
- PRESET asserted mid-transfer: the next edge forces IDLE with all outputs at reset values; any in-flight or pending response is dropped.
- cmd_* inputs are sampled only at the accept edge; later changes have no effect.

Decomposition:
- Shared package apb_pkg:
  - apb_state_e enum {IDLE, SETUP, ACCESS, RESP}.
  - apb_cmd_t struct (addr, write, wdata, strb, prot).
  - apb_rsp_t struct (rdata, slverr, timeout).
  - Localparam PPROT_W = 3.
- One natural sub-module, apb_wait_timer:
  - Inputs: clear, count-enable.
  - Output: expired.
  - Parameter: TIMEOUT_CYCLES, with 0 meaning never expire.

Test Plan:
- Write addr 0x10, data 0xDEADBEEF, strb 0xF, PREADY tied 1 -> PSEL high 2 cycles, PENABLE high 1 cycle, PWDATA 0xDEADBEEF stable; rsp_valid at N+3 with slverr 0, timeout 0, rdata 0.
- Read addr 0x20, PREADY low for 3 ACCESS cycles, PRDATA 0x12345678 -> PADDR/PPROT stable across all waits; PSTRB 0; rsp_rdata 0x12345678 after the 4th ACCESS cycle.
- Read with PSLVERR = 1 on the completing cycle -> rsp_slverr 1, rsp_timeout 0; bridge returns to IDLE after rsp_ready.
- Slave never asserts PREADY, TIMEOUT_CYCLES = 16 -> exactly 16 ACCESS cycles, then PSEL/PENABLE drop; rsp_timeout 1, rsp_slverr 1, rdata 0.
- rsp_ready held low 5 cycles with cmd_valid high -> rsp fields stable, cmd_ready 0, no APB activity; after rsp_ready, IDLE cycle, then the next command is accepted.
- PRESET pulsed during ACCESS -> next cycle all APB outputs 0, rsp_valid 0, cmd_ready 0 while reset is high, and 1 in the first cycle after reset.
